// File: rtl/ramreq_pkg.sv
// rtl/ramreq_pkg.sv - shared constants and types for the ramreq requester
package ramreq_pkg;

  // Response buffer depth; together with the pend flag this bounds outstanding reads.
  localparam int FIFO_DEPTH = 2;

  // Occupancy of the response FIFO (0..FIFO_DEPTH).
  typedef logic [1:0] cnt_t;

endpackage

// File: rtl/ramreq_fifo.sv
// rtl/ramreq_fifo.sv - 2-entry in-order response FIFO
//
// Ports:
//   clk, nreset : clock, synchronous active-low reset (empties the FIFO)
//   push, din   : write din at the tail
//   pop         : drop the head entry
//   dout        : current head entry (valid when count != 0)
//   count       : number of stored entries
module ramreq_fifo
  import ramreq_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output cnt_t          count
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          wptr;
  logic          rptr;

  // Pointers and count carry the reset; the storage itself does not need one.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (nreset && push) mem[wptr] <= din;
  end

  assign dout = mem[rptr];

endmodule

// File: rtl/ramreq.sv
// rtl/ramreq.sv - valid/ready requester front-end for a byte-masked sync RAM
//
// Ports:
//   clk, nreset                          : clock, synchronous active-low reset
//   req_valid/req_ready                  : request handshake
//   req_write, req_wmask, req_addr, req_data : request payload
//   rsp_valid/rsp_ready, rsp_data        : in-order read response channel
//   mem_ce, mem_we, mem_addr, mem_din    : RAM drive (combinational from accepted request)
//   mem_dout                             : RAM read data, one cycle after the access
module ramreq
  import ramreq_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [DW/8-1:0] req_wmask,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_data,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            mem_ce,
  output logic [DW/8-1:0] mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  input  logic [DW-1:0]   mem_dout
);

  localparam int BW = DW / 8;

  logic          pend;        // a read was accepted last cycle; mem_dout holds its data now
  cnt_t          fifo_count;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [2:0]    occ;
  logic          popped;
  logic          acc;

  assign fifo_empty = (fifo_count == '0);
  assign occ        = {1'b0, fifo_count} + {2'b00, pend};

  // Bypass: with an empty FIFO the freshly returned RAM word is presented directly.
  assign rsp_valid = nreset & (pend | ~fifo_empty);
  assign rsp_data  = fifo_empty ? mem_dout : fifo_dout;
  assign popped    = rsp_valid & rsp_ready;

  // Credit: a read may fill the last slot only if a response leaves this cycle.
  assign req_ready = nreset & (req_write | (occ < 3'd2) | ((occ == 3'd2) & popped));
  assign acc       = req_valid & req_ready;

  assign mem_ce   = acc;
  assign mem_addr = req_addr;
  assign mem_din  = req_data;
  assign mem_we   = (acc & req_write) ? req_wmask : {BW{1'b0}};

  // mem_dout is only valid for this one cycle, so it must be consumed or stored now.
  assign fifo_push = nreset & pend & ~(fifo_empty & rsp_ready);
  assign fifo_pop  = nreset & ~fifo_empty & rsp_ready;

  always_ff @(posedge clk) begin
    if (!nreset) pend <= 1'b0;
    else         pend <= acc & ~req_write;
  end

  ramreq_fifo #(.DW(DW)) u_fifo (
    .clk    (clk),
    .nreset (nreset),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (mem_dout),
    .dout   (fifo_dout),
    .count  (fifo_count)
  );

endmodule
